// File: rtl/mpmc12_wdf_burst_gen.sv
// mpmc12_wdf_burst_gen
// Write-data burst sequencer for the mpmc12 memory controller. Accepts a burst request
// (burst_len+1 commands, DPC app_wdf beats per command), pops beats from the port write
// buffer and presents them to the MIG write-data FIFO, holding everything stable under
// app_wdf_rdy backpressure. app_wdf_end marks the last beat of each command.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start, burst_len    burst request (sampled only when idle), commands minus one
//   dat_valid, dat_i,
//   mask_i, dat_rd      write-buffer side; dat_rd pops one beat
//   app_wdf_*           MIG write-data FIFO side
//   busy, done, err     status; done pulses with the final acceptance
//
// Optional feature: define MPMC12_WDF_WATCHDOG_EN to build a stall watchdog that aborts
// the burst and raises a sticky err after TMO consecutive backpressured cycles.
module mpmc12_wdf_burst_gen #(
    parameter int unsigned DW  = 128,
    parameter int unsigned MW  = DW / 8,
    parameter int unsigned BLW = 6,
    parameter int unsigned DPC = 1,
    parameter int unsigned TMO = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [BLW-1:0] burst_len,
    input  logic           dat_valid,
    input  logic [DW-1:0]  dat_i,
    input  logic [MW-1:0]  mask_i,
    output logic           dat_rd,
    input  logic           app_wdf_rdy,
    output logic           app_wdf_wren,
    output logic [DW-1:0]  app_wdf_data,
    output logic [MW-1:0]  app_wdf_mask,
    output logic           app_wdf_end,
    output logic           busy,
    output logic           done,
    output logic           err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [BLW-1:0] len_q, len_d;
    logic [BLW:0]   cnt_q, cnt_d;
    logic           wren_q, wren_d;
    logic           end_q, end_d;
    logic [DW-1:0]  data_q, data_d;
    logic [MW-1:0]  mask_q, mask_d;
    logic           pop;
    logic           fin;
    logic           abort;
    logic [BLW:0]   cnt_nxt;
    logic [BLW:0]   last_idx;
    logic           is_last;

    assign cnt_nxt = cnt_q + (BLW + 1)'(1);
    // Index of the final beat, (burst_len+1)*DPC - 1, without a multiplier.
    assign last_idx = (DPC == 2) ? {len_q, 1'b1} : {1'b0, len_q};
    assign is_last  = (cnt_q == last_idx);

`ifdef MPMC12_WDF_WATCHDOG_EN
    localparam int unsigned TW = $clog2(TMO + 1);

    logic [TW-1:0] wd_q;
    logic          err_q;
    logic          stall;

    assign stall = (state_q == PRESENT) && !app_wdf_rdy;
    assign abort = stall && (wd_q == TW'(TMO - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            if (stall && !abort) wd_q <= wd_q + TW'(1);
            else                 wd_q <= '0;
            if (abort) err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign abort = 1'b0;
    assign err   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        wren_d  = wren_q;
        end_d   = end_q;
        data_d  = data_q;
        mask_d  = mask_q;
        pop     = 1'b0;
        fin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = burst_len;
                    cnt_d   = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                if (dat_valid) begin
                    data_d  = dat_i;
                    mask_d  = mask_i;
                    end_d   = (DPC == 1) ? 1'b1 : cnt_q[0];
                    wren_d  = 1'b1;
                    pop     = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (app_wdf_rdy) begin
                    if (is_last) begin
                        wren_d  = 1'b0;
                        end_d   = 1'b0;
                        fin     = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_nxt;
                        if (dat_valid) begin
                            // Back-to-back load keeps one beat per cycle.
                            data_d = dat_i;
                            mask_d = mask_i;
                            end_d  = (DPC == 1) ? 1'b1 : cnt_nxt[0];
                            pop    = 1'b1;
                        end else begin
                            // Drop wren rather than re-present stale data.
                            wren_d  = 1'b0;
                            end_d   = 1'b0;
                            state_d = FETCH;
                        end
                    end
                end else if (abort) begin
                    wren_d  = 1'b0;
                    end_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                wren_d  = 1'b0;
                end_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            wren_q  <= 1'b0;
            end_q   <= 1'b0;
            data_q  <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            wren_q  <= wren_d;
            end_q   <= end_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
        end
    end

    // Strobes are gated by reset so an abandoned burst can never pop or signal done.
    assign dat_rd       = pop && rst_n;
    assign done         = fin && rst_n;
    assign busy         = (state_q != IDLE);
    assign app_wdf_wren = wren_q;
    assign app_wdf_end  = end_q;
    assign app_wdf_data = data_q;
    assign app_wdf_mask = mask_q;

endmodule

// File: tb/tb_mpmc12_wdf_burst_gen.sv
// Directed bench for mpmc12_wdf_burst_gen: a DPC=1 and a DPC=2 instance share the input
// stimulus; a small write-buffer model supplies numbered beats so data order, duplicate
// pops and skipped pops all show up as data mismatches.
module tb_mpmc12_wdf_burst_gen;

    localparam int unsigned DW  = 128;
    localparam int unsigned MW  = 16;
    localparam int unsigned BLW = 6;
    localparam int unsigned TMO = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start1, start2;
    logic [BLW-1:0] blen;
    logic           dv;
    logic [DW-1:0]  di;
    logic [MW-1:0]  mi;
    logic           rdy;

    logic           rd1, wren1, end1, busy1, done1, err1;
    logic [DW-1:0]  data1;
    logic [MW-1:0]  mask1;
    logic           rd2, wren2, end2, busy2, done2, err2;
    logic [DW-1:0]  data2;
    logic [MW-1:0]  mask2;

    logic           sel = 1'b0;
    logic           rd_s, wren_s, end_s, busy_s, done_s, err_s;
    logic [DW-1:0]  data_s;
    logic [MW-1:0]  mask_s;

    int unsigned    ptr = 0;
    int unsigned    base;
    int             n_checks = 0;
    int             n_fail = 0;

    always #5 clk = ~clk;

    mpmc12_wdf_burst_gen #(.DW(DW), .MW(MW), .BLW(BLW), .DPC(1), .TMO(TMO)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .burst_len(blen),
        .dat_valid(dv), .dat_i(di), .mask_i(mi), .dat_rd(rd1),
        .app_wdf_rdy(rdy), .app_wdf_wren(wren1), .app_wdf_data(data1),
        .app_wdf_mask(mask1), .app_wdf_end(end1), .busy(busy1), .done(done1), .err(err1)
    );

    mpmc12_wdf_burst_gen #(.DW(DW), .MW(MW), .BLW(BLW), .DPC(2), .TMO(TMO)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .burst_len(blen),
        .dat_valid(dv), .dat_i(di), .mask_i(mi), .dat_rd(rd2),
        .app_wdf_rdy(rdy), .app_wdf_wren(wren2), .app_wdf_data(data2),
        .app_wdf_mask(mask2), .app_wdf_end(end2), .busy(busy2), .done(done2), .err(err2)
    );

    function automatic logic [DW-1:0] pat_d(input int unsigned p);
        logic [31:0] w;
        w = 32'hC0DE_0000 + p;
        return {4{w}};
    endfunction

    function automatic logic [MW-1:0] pat_m(input int unsigned p);
        logic [31:0] w;
        w = p;
        return 16'h5A5A ^ w[15:0];
    endfunction

    assign di     = pat_d(ptr);
    assign mi     = pat_m(ptr);
    assign rd_s   = sel ? rd2 : rd1;
    assign wren_s = sel ? wren2 : wren1;
    assign end_s  = sel ? end2 : end1;
    assign busy_s = sel ? busy2 : busy1;
    assign done_s = sel ? done2 : done1;
    assign err_s  = sel ? err2 : err1;
    assign data_s = sel ? data2 : data1;
    assign mask_s = sel ? mask2 : mask1;

    // Write-buffer model: each pop advances to the next numbered beat.
    always @(posedge clk) begin
        if (rd_s) ptr <= ptr + 1;
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic run_stream(input bit s, input int len, input int dpc);
        int n;
        n     = (len + 1) * dpc;
        sel   = s;
        dv    = 1'b1;
        rdy   = 1'b1;
        blen  = BLW'(len);
        base  = ptr;
        tick();
        if (s) start2 = 1'b1;
        else   start1 = 1'b1;
        #1 check("str_idle_busy", busy_s, 0);
        tick();
        start1 = 1'b0;
        start2 = 1'b0;
        #1;
        check("str_busy", busy_s, 1);
        check("str_first_rd", rd_s, 1);
        check("str_first_wren", wren_s, 0);
        for (int k = 0; k < n; k++) begin
            tick();
            #1;
            check("str_wren", wren_s, 1);
            check("str_data", data_s, pat_d(base + k));
            check("str_mask", mask_s, pat_m(base + k));
            check("str_end", end_s, ((dpc == 1) || (k % 2 == 1)) ? 1 : 0);
            check("str_done", done_s, (k == n - 1) ? 1 : 0);
            check("str_rd", rd_s, (k == n - 1) ? 0 : 1);
        end
        tick();
        #1;
        check("str_post_busy", busy_s, 0);
        check("str_post_wren", wren_s, 0);
        check("str_post_done", done_s, 0);
        check("str_pops", ptr - base, n);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n  = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        blen   = '0;
        dv     = 1'b1;
        rdy    = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_wren", wren1, 0);
        check("rst_end", end1, 0);
        check("rst_data", data1, 0);
        check("rst_mask", mask1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        check("rst_rd", rd1, 0);
        check("rst_err", err1, 0);
        check("rst_wren2", wren2, 0);
        check("rst_busy2", busy2, 0);
        tick();
        rst_n = 1'b1;

        // Single beat, DPC=1
        run_stream(1'b0, 0, 1);
        // 4 commands x 2 beats, DPC=2
        run_stream(1'b1, 3, 2);

        // Backpressure on beat 1 of 3
        sel  = 1'b0;
        blen = 6'd2;
        base = ptr;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        #1 check("bp_fetch_rd", rd1, 1);
        tick();
        #1;
        check("bp_b0_data", data1, pat_d(base));
        check("bp_b0_rd", rd1, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            rdy = 1'b0;
            #1;
            check("bp_stall_wren", wren1, 1);
            check("bp_stall_data", data1, pat_d(base + 1));
            check("bp_stall_mask", mask1, pat_m(base + 1));
            check("bp_stall_end", end1, 1);
            check("bp_stall_rd", rd1, 0);
            check("bp_stall_done", done1, 0);
        end
        tick();
        rdy = 1'b1;
        #1;
        check("bp_release_data", data1, pat_d(base + 1));
        check("bp_release_rd", rd1, 1);
        tick();
        #1;
        check("bp_b2_data", data1, pat_d(base + 2));
        check("bp_b2_done", done1, 1);
        tick();
        #1;
        check("bp_post_busy", busy1, 0);
        check("bp_pops", ptr - base, 3);

        // Data gap of 3 cycles inside a 4-beat burst
        blen = 6'd3;
        base = ptr;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        #1 check("gap_fetch_rd", rd1, 1);
        tick();
        #1;
        check("gap_b0_data", data1, pat_d(base));
        check("gap_b0_rd", rd1, 1);
        tick();
        dv = 1'b0;
        #1;
        check("gap_b1_data", data1, pat_d(base + 1));
        check("gap_b1_wren", wren1, 1);
        check("gap_b1_rd", rd1, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            #1;
            check("gap_wren", wren1, 0);
            check("gap_rd", rd1, 0);
            check("gap_busy", busy1, 1);
        end
        tick();
        dv = 1'b1;
        #1;
        check("gap_refetch_wren", wren1, 0);
        check("gap_refetch_rd", rd1, 1);
        tick();
        #1;
        check("gap_b2_data", data1, pat_d(base + 2));
        check("gap_b2_rd", rd1, 1);
        tick();
        #1;
        check("gap_b3_data", data1, pat_d(base + 3));
        check("gap_b3_done", done1, 1);
        tick();
        #1;
        check("gap_post_busy", busy1, 0);
        check("gap_pops", ptr - base, 4);

        // Reset while presenting beat 2 of 4
        base = ptr;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mrst_in_data", data1, pat_d(base + 2));
        check("mrst_in_rd", rd1, 0);
        check("mrst_in_done", done1, 0);
        tick();
        #1;
        check("mrst_wren", wren1, 0);
        check("mrst_end", end1, 0);
        check("mrst_data", data1, 0);
        check("mrst_mask", mask1, 0);
        check("mrst_busy", busy1, 0);
        check("mrst_done", done1, 0);
        check("mrst_rd", rd1, 0);
        check("mrst_pops", ptr - base, 3);
        tick();
        rst_n = 1'b1;
        run_stream(1'b0, 1, 1);

        // Indefinite stall: watchdog abort if built, otherwise keeps waiting
        sel  = 1'b0;
        blen = 6'd0;
        tick();
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick();
            rdy = 1'b0;
            #1;
            check("wd_stall_wren", wren1, 1);
            check("wd_stall_err", err1, 0);
        end
        tick();
        #1;
`ifdef MPMC12_WDF_WATCHDOG_EN
        check("wd_err", err1, 1);
        check("wd_busy", busy1, 0);
        check("wd_wren", wren1, 0);
        check("wd_done", done1, 0);
        rdy = 1'b1;
        repeat (3) tick();
        #1;
        check("wd_err_sticky", err1, 1);
        check("wd_no_done", done1, 0);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1 check("wd_err_cleared", err1, 0);
`else
        check("nowd_err", err1, 0);
        check("nowd_wren", wren1, 1);
        check("nowd_busy", busy1, 1);
        tick();
        rdy = 1'b1;
        #1 check("nowd_done", done1, 1);
        tick();
        #1 check("nowd_post_busy", busy1, 0);
`endif

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
